// File: rtl/spike_readout_decoder.sv
// Purpose : rate-decoding linear readout; counts spikes per neuron over a window of enabled cycles and forms a weighted Q6.10 sum.
// Latency : N_NEURONS clock edges from the window-closing edge to y_out/y_valid.
// Backpres: none; a window closing while the MAC is busy is dropped and flagged on the sticky overrun output.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   en                 sample enable; gates spike counting and window advance
//   spikes_in          one spike bit per neuron for this cycle
//   w_we/w_addr/w_data weight write port (signed Q6.10), out-of-range addresses ignored
//   y_out, y_valid     saturated Q6.10 estimate and its one-cycle update strobe
//   busy, overrun      MAC running; sticky flag for a window lost to a busy MAC
module spike_readout_decoder #(
    parameter int N_NEURONS = 10,
    parameter int WINDOW    = 32,
    parameter int CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_NEURONS-1:0]         spikes_in,
    input  logic                         w_we,
    input  logic [$clog2(N_NEURONS)-1:0] w_addr,
    input  logic [15:0]                  w_data,
    output logic [15:0]                  y_out,
    output logic                         y_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ADDR_W = $clog2(N_NEURONS);
    localparam int LOG2W  = $clog2(WINDOW);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAC  = 1'b1;

    localparam logic [CNT_W-1:0]  WCNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(N_NEURONS - 1);

    logic [CNT_W-1:0]   cnt  [N_NEURONS];
    logic [CNT_W-1:0]   snap [N_NEURONS];
    logic signed [15:0] w    [N_NEURONS];
    logic [CNT_W-1:0]   wcnt;
    logic [ADDR_W-1:0]  k;
    logic signed [31:0] acc;
    logic [0:0]         state;

    logic signed [31:0] snap_ext;
    logic signed [31:0] w_ext;
    logic signed [31:0] mac_sum;
    logic signed [31:0] shifted;
    logic [15:0]        y_sat;
    logic               addr_ok;

    // Widen the address by one bit so a power-of-two N_NEURONS still compares correctly.
    assign addr_ok = ({1'b0, w_addr} < (ADDR_W + 1)'(N_NEURONS));
    assign busy    = (state == S_MAC);

    // Current MAC term; snap is an unsigned count, the weight is signed.
    always_comb begin
        snap_ext = 32'(snap[k]);
        w_ext    = 32'(w[k]);
        mac_sum  = acc + snap_ext * w_ext;
        shifted  = mac_sum >>> LOG2W;   // divide by WINDOW, rounding toward -inf
        y_sat    = shifted[15:0];
        if (shifted > 32'sd32767) begin
            y_sat = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            y_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk) begin
        y_valid <= 1'b0;
        if (!reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cnt[i]  <= '0;
                snap[i] <= '0;
                w[i]    <= '0;
            end
            wcnt    <= '0;
            k       <= '0;
            acc     <= '0;
            state   <= S_IDLE;
            y_out   <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_we && addr_ok) begin
                w[w_addr] <= w_data;
            end

            if (en) begin
                if (wcnt == WCNT_LAST) begin
                    // Closing cycle's spikes belong to the window being snapped.
                    for (int i = 0; i < N_NEURONS; i++) begin
                        cnt[i] <= '0;
                    end
                    wcnt <= '0;
                    if (state == S_IDLE) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            snap[i] <= cnt[i] + CNT_W'(spikes_in[i]);
                        end
                        state <= S_MAC;
                        k     <= '0;
                        acc   <= '0;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        cnt[i] <= cnt[i] + CNT_W'(spikes_in[i]);
                    end
                    wcnt <= wcnt + CNT_W'(1);
                end
            end

            if (state == S_MAC) begin
                if (k == K_LAST) begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                    state   <= S_IDLE;
                end else begin
                    acc <= mac_sum;
                    k   <= k + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_readout_decoder.sv
module tb_spike_readout_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [9:0]  spikes_in;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [15:0] w_data;

    logic [15:0] y_out,   y_out8;
    logic        y_valid, y_valid8;
    logic        busy,    busy8;
    logic        overrun, overrun8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spike_readout_decoder #(.N_NEURONS(10), .WINDOW(32)) dut (
        .clk(clk), .reset(reset), .en(en), .spikes_in(spikes_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    spike_readout_decoder #(.N_NEURONS(10), .WINDOW(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .spikes_in(spikes_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .y_out(y_out8), .y_valid(y_valid8), .busy(busy8), .overrun(overrun8)
    );

    // One rising edge; outputs are sampled and inputs redriven 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        en        = 1'b0;
        spikes_in = '0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic write_w(input logic [3:0] a, input logic [15:0] d);
        w_we   = 1'b1;
        w_addr = a;
        w_data = d;
        step();
        w_we   = 1'b0;
    endtask

    // Drives edges n = 1, 2, ... until the first y_valid; at = -1 if none within budget.
    task automatic run_window(input logic [9:0] every, input logic [9:0] alt, input bit gate,
                              output int at, output logic [15:0] y);
        at = -1;
        y  = 16'hxxxx;
        for (int n = 1; n <= 120; n++) begin
            en        = gate ? n[0] : 1'b1;
            spikes_in = every | (n[0] ? alt : 10'h000);
            step();
            if (y_valid) begin
                at = n;
                y  = y_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (y_out !== 16'h0000) begin fails++; $display("FAIL reset_y_out: got %h want 0000", y_out); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests++; if (y_out8 !== 16'h0000 || busy8 !== 1'b0 || overrun8 !== 1'b0) begin
            fails++; $display("FAIL reset_w8: got y=%h busy=%b ovr=%b want 0000/0/0", y_out8, busy8, overrun8);
        end
    endtask

    task automatic test_unity();
        int at;
        logic [15:0] y;
        do_reset();
        write_w(4'd0, 16'h0400);
        run_window(10'h001, 10'h000, 1'b0, at, y);
        tests++; if (at !== 42) begin fails++; $display("FAIL unity_first_latency: got %0d want 42", at); end
        tests++; if (y !== 16'h0400) begin fails++; $display("FAIL unity_y1: got %h want 0400", y); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL unity_busy_on_valid: got %b want 0", busy); end
        run_window(10'h001, 10'h000, 1'b0, at, y);
        tests++; if (at !== 32) begin fails++; $display("FAIL unity_period: got %0d want 32", at); end
        tests++; if (y !== 16'h0400) begin fails++; $display("FAIL unity_y2: got %h want 0400", y); end
    endtask

    task automatic test_signed_mix();
        int at;
        logic [15:0] y;
        do_reset();
        write_w(4'd0, 16'h0400);
        write_w(4'd1, 16'hFC00);
        run_window(10'h002, 10'h001, 1'b0, at, y);
        tests++; if (at !== 42) begin fails++; $display("FAIL mix_latency: got %0d want 42", at); end
        tests++; if (y !== 16'hFE00) begin fails++; $display("FAIL mix_y: got %h want FE00", y); end
    endtask

    task automatic test_saturation();
        int at;
        logic [15:0] y;
        do_reset();
        for (int i = 0; i < 10; i++) write_w(4'(i), 16'h7FFF);
        write_w(4'd12, 16'h0001);   // out-of-range address, must be ignored
        run_window(10'h3FF, 10'h000, 1'b0, at, y);
        tests++; if (y !== 16'h7FFF) begin fails++; $display("FAIL sat_pos: got %h want 7FFF (at %0d)", y, at); end
        do_reset();
        for (int i = 0; i < 10; i++) write_w(4'(i), 16'h8000);
        run_window(10'h3FF, 10'h000, 1'b0, at, y);
        tests++; if (y !== 16'h8000) begin fails++; $display("FAIL sat_neg: got %h want 8000 (at %0d)", y, at); end
    endtask

    task automatic test_enable_gating();
        int at;
        logic [15:0] y;
        do_reset();
        write_w(4'd0, 16'h0400);
        run_window(10'h001, 10'h000, 1'b1, at, y);
        tests++; if (at !== 73) begin fails++; $display("FAIL gate_latency: got %0d want 73", at); end
        tests++; if (y !== 16'h0400) begin fails++; $display("FAIL gate_y: got %h want 0400", y); end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        int p_at[2] = '{-1, -1};
        logic [15:0] p_y[2] = '{16'hxxxx, 16'hxxxx};
        do_reset();
        write_w(4'd0, 16'h0400);
        for (int n = 1; n <= 40; n++) begin
            en        = 1'b1;
            spikes_in = 10'h001;
            step();
            if (n == 8) begin
                tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL ovr_busy_at_close: got %b want 1", busy8); end
            end
            if (n == 15) begin
                tests++; if (overrun8 !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b want 0", overrun8); end
            end
            if (n == 16) begin
                tests++; if (overrun8 !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun8); end
            end
            if (y_valid8) begin
                if (pulses < 2) begin
                    p_at[pulses] = n;
                    p_y[pulses]  = y_out8;
                end
                pulses++;
            end
        end
        tests++; if (pulses !== 2) begin fails++; $display("FAIL ovr_pulse_count: got %0d want 2", pulses); end
        tests++; if (p_at[0] !== 18 || p_y[0] !== 16'h0400) begin
            fails++; $display("FAIL ovr_pulse1: got at %0d y %h want 18 0400", p_at[0], p_y[0]);
        end
        tests++; if (p_at[1] !== 34 || p_y[1] !== 16'h0400) begin
            fails++; $display("FAIL ovr_pulse2: got at %0d y %h want 34 0400", p_at[1], p_y[1]);
        end
        tests++; if (overrun8 !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun8); end
    endtask

    task automatic test_reset_mid_mac();
        int at;
        int pulses = 0;
        logic [15:0] y;
        do_reset();
        write_w(4'd0, 16'h0400);
        run_window(10'h001, 10'h000, 1'b0, at, y);
        tests++; if (y !== 16'h0400) begin fails++; $display("FAIL rmid_pre_y: got %h want 0400", y); end
        for (int n = 1; n <= 24; n++) step();   // second window closes at n = 22
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b want 1", busy); end
        reset = 1'b0;
        step();
        tests++; if (y_out !== 16'h0000 || y_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            fails++; $display("FAIL rmid_outputs: got y=%h v=%b busy=%b ovr=%b want 0000/0/0/0",
                              y_out, y_valid, busy, overrun);
        end
        reset     = 1'b1;
        en        = 1'b0;
        spikes_in = '0;
        for (int n = 1; n <= 15; n++) begin
            step();
            if (y_valid) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL rmid_no_valid: got %0d pulses want 0", pulses); end
        // Weights were cleared by the reset, so a full window now reads out zero.
        run_window(10'h001, 10'h000, 1'b0, at, y);
        tests++; if (at !== 42 || y !== 16'h0000) begin
            fails++; $display("FAIL rmid_weights_cleared: got at %0d y %h want 42 0000", at, y);
        end
    endtask

    task automatic test_write_hazard();
        int pulses = 0;
        int p_at[2] = '{-1, -1};
        logic [15:0] p_y[2] = '{16'hxxxx, 16'hxxxx};
        do_reset();
        write_w(4'd3, 16'h0400);
        for (int n = 1; n <= 80; n++) begin
            en        = 1'b1;
            spikes_in = 10'h008;
            // Window closes at edge 32, so k == 3 is the value before edge 36.
            w_we   = (n == 36);
            w_addr = 4'd3;
            w_data = 16'h0800;
            step();
            if (y_valid) begin
                if (pulses < 2) begin
                    p_at[pulses] = n;
                    p_y[pulses]  = y_out;
                end
                pulses++;
            end
        end
        w_we = 1'b0;
        tests++; if (p_at[0] !== 42 || p_y[0] !== 16'h0400) begin
            fails++; $display("FAIL hazard_old_weight: got at %0d y %h want 42 0400", p_at[0], p_y[0]);
        end
        tests++; if (p_at[1] !== 74 || p_y[1] !== 16'h0800) begin
            fails++; $display("FAIL hazard_new_weight: got at %0d y %h want 74 0800", p_at[1], p_y[1]);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_signed_mix();
        test_saturation();
        test_enable_gating();
        test_overrun();
        test_reset_mid_mac();
        test_write_hazard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spike_readout_decoder.md
# spike_readout_decoder

Rate-decoding linear readout at the output end of the LIF reservoir: the inverse of `bitstream_converter`, which encodes a Q6.10 NARMA sample into spike drive. It counts spikes on each neuron's `i_out` over a fixed window of enabled cycles, then forms a weighted sum of the per-neuron rates with programmable Q6.10 weights. It emits one saturated Q6.10 estimate of the NARMA target per window, for comparison against `narma_output`.

## Interface
- `N_NEURONS`, 10: number of spike inputs.
- `WINDOW`, 32: enabled cycles per integration window; power of two, ≥ 2.
- `CNT_W`, `$clog2(WINDOW+1)`: per-neuron counter width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `en`  in  1  sample enable; spikes are counted and the window advances only when high.
- `spikes_in`  in  N_NEURONS  bit i = `i_out` of neuron i in this cycle.
- `w_we`  in  1  weight write strobe.
- `w_addr`  in  `$clog2(N_NEURONS)`  weight index; writes with index ≥ N_NEURONS are ignored.
- `w_data`  in  16  signed Q6.10 weight.
- `y_out`  out  16  signed Q6.10 readout, held between updates.
- `y_valid`  out  1  one-cycle pulse when `y_out` is updated.
- `busy`  out  1  high while the MAC is running.
- `overrun`  out  1  sticky; set when a window closes while `busy` is high.

## Operation
- **Counters**
  - On an edge with `en`=1: `cnt[i] += spikes_in[i]` and `wcnt += 1`.
  - With `en`=0: counters and `wcnt` hold.
- **Window close** (edge with `en`=1 and `wcnt`==WINDOW-1):
  - `snap[i] <= cnt[i] + spikes_in[i]`, so the closing cycle is counted.
  - `cnt` and `wcnt` clear to 0.
  - If state==IDLE, the state becomes MAC with `k`=0 and `acc`=0.
  - If state==MAC, the snapshot is discarded, `overrun` is set to 1, and the MAC continues undisturbed.
- **States:** IDLE and MAC. `busy` = (state==MAC).
- **MAC**, one term per edge:
  - `acc <= acc + snap[k]*w[k]`.
  - `snap[k]` is zero-extended to signed; `w[k]` is signed 16-bit; `acc` is 32-bit signed.
  - The design assumes N_NEURONS·WINDOW ≤ 65536, so `acc` never wraps.
- **Last term** (`k`==N_NEURONS-1):
  - `s = acc + snap[k]*w[k]`.
  - `y_out <= sat16(s >>> log2(WINDOW))`, using an arithmetic shift (floor).
  - `sat16` clamps the result to [0x8000, 0x7FFF].
  - `y_valid <= 1` for one cycle; state goes to IDLE.
- **Weights:** `w[w_addr] <= w_data` on an edge with `w_we`=1, accepted in any state.
  - The MAC reads the pre-edge value, so a write to `w[k]` on the same edge affects only later windows.
- **Counting during MAC:** spike counting continues during MAC; the window and the MAC are independent.
- **Reset** (`reset`=0 at an edge) sets all of the following, including mid-MAC (the aborted MAC produces no `y_valid`):
  - `cnt`, `snap`, `wcnt`, `acc`, `k` = 0.
  - All weights = 0; state = IDLE.
  - `y_out`=0x0000, `y_valid`=0, `busy`=0, `overrun`=0.

## Timing
- Window close at edge E0 → `busy` high from E0+ onward.
- Terms 0..N-2 are added at edges E1..E(N-1).
- The final term plus output register load happen at edge EN.
- `y_valid` is high for the single cycle after EN; `busy` is low in that same cycle.
- Latency is N_NEURONS edges from window close to `y_out` valid (10 with defaults).
- A window close on the edge where the MAC finishes (state still MAC) is an overrun.
- A window close on the edge after that (state IDLE, `y_valid` high) starts a new MAC normally.
- `overrun` cannot occur when WINDOW > N_NEURONS and `en` is held high.
- `en` is ignored by the MAC; `y_out` changes only on `y_valid` cycles and on reset.

## Test plan
- **Single-neuron unity weight:**
  - Stimulus: reset, `w[0]`=0x0400, others 0; `spikes_in[0]`=1 every cycle, `en`=1.
  - Response: `y_out`=0x0400 on each `y_valid`, pulse every 32 cycles, first pulse 10 cycles after the 32nd enabled edge.
- **Signed mix:**
  - Stimulus: `w[0]`=0x0400, `w[1]`=0xFC00; neuron 0 spikes on alternate cycles, neuron 1 every cycle.
  - Response: `snap[0]`=16, `snap[1]`=32, `y_out`=0xFE00 (-0.5).
- **Saturation:**
  - Stimulus: all weights 0x7FFF, all neurons spike every cycle.
  - Response: s=10485440, shifted 327670, `y_out`=0x7FFF; with all weights 0x8000, `y_out`=0x8000.
- **Enable gating:**
  - Stimulus: neuron 0 spiking continuously, `en` toggled 1/0 each cycle, `w[0]`=0x0400.
  - Response: window closes after 64 clocks, `y_out`=0x0400 (spikes while `en`=0 not counted).
- **Overrun:**
  - Stimulus: instance with WINDOW=8, N_NEURONS=10, `en`=1.
  - Response: second window close lands in MAC, `overrun`=1 and stays; `y_valid` continues from accepted windows only.
- **Reset and write hazard:**
  - Stimulus: reset mid-MAC; separately, write `w[3]` on the edge where k=3.
  - Response: after reset, all outputs 0 and no `y_valid`; the write case uses the old `w[3]` for that window and the new value for the next.
